square_multi_cycle: RTL and testbench
=====================================

# square_multi_cycle

Iterative inverse of the integer square-root datapath: takes a root `r` and remainder `m` and reconstructs the original argument `r*r + m` with a sequential shift-add multiplier. It sits after the root unit in verification and loopback paths, and serves as a reconstruction stage wherever a root/remainder pair must be expanded back to a full-width value. The block uses a valid/ready handshake on both sides and holds one operation in flight.

## Interface
- `DATA_WIDTH`, 8: width of the reconstructed value. Must be even and ≥ 4. Root width is `DATA_WIDTH/2`; remainder width is `DATA_WIDTH/2+1`.
- Clock and reset: one clock; reset is asynchronous and active-low (`clk`, `rst_n`).
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `arg_vld`  in  1  input operands valid.
- `arg_rdy`  out  1  block can accept operands; high only in IDLE.
- `arg_root`  in  DATA_WIDTH/2  root `r`.
- `arg_rem`  in  DATA_WIDTH/2+1  remainder `m`.
- `res_vld`  out  1  result valid; high only in DONE.
- `res_rdy`  in  1  downstream accepts the result.
- `res`  out  DATA_WIDTH  reconstructed value `(r*r + m) mod 2^DATA_WIDTH`.
- `res_err`  out  1  `m > 2*r`, meaning the pair is not a legal sqrt output.

## Operation
- **FSM states:** IDLE, MUL, ADD, DONE. Outputs are decoded from registered state: `arg_rdy = (state==IDLE)` and `res_vld = (state==DONE)`.
- **IDLE:**
  - Accept on an edge with `arg_vld && arg_rdy`.
  - Capture `mcand = root` (zero-extended to DATA_WIDTH), `mplier = root`, `rem = arg_rem`, `acc = 0`, `cnt = 0`.
  - Capture `err = (arg_rem > {1'b0,arg_root,1'b0})`, using a DATA_WIDTH/2+1-bit compare.
  - Go to MUL.
  - Operands are sampled only on the accept edge and ignored at all other times.
- **MUL:** one iteration per edge, DATA_WIDTH/2 iterations in total:
  - If `mplier[0]`, then `acc += mcand` (DATA_WIDTH bits, no overflow possible).
  - `mcand <<= 1`, `mplier >>= 1`, `cnt++`.
  - Go to ADD on the edge where `cnt == DATA_WIDTH/2-1`.
- **ADD:** `acc += rem` (zero-extended, result truncated to DATA_WIDTH bits), then go to DONE. For legal pairs the sum is at most `2^DATA_WIDTH-1`, so it never wraps. Illegal pairs wrap silently and are flagged by `res_err`.
- **DONE:**
  - `res = acc` and `res_err = err`, both held stable while `res_rdy` is low.
  - On an edge with `res_rdy` high, go to IDLE.
  - `res` and `res_err` keep their values after the handshake until the next ADD.
- No pass-through: a new operand is never accepted in the same cycle a result is consumed.

## Timing
- **Reset values:** state=IDLE, `arg_rdy=1`, `res_vld=0`, `res=0`, `res_err=0`. All internal registers are cleared.
- **Latency:** with the accept edge as E0, MUL runs on E1..E(W/2), ADD on E(W/2+1). `res_vld` rises after E(W/2+1), i.e. DATA_WIDTH/2+1 cycles after acceptance (5 for W=8).
- **Throughput:** with `arg_vld` and `res_rdy` held high, one accept every DATA_WIDTH/2+3 cycles (7 for W=8).
- **Backpressure:** while `res_rdy` is low, DONE is held indefinitely and `arg_rdy` stays 0.
- **Reset asserted in any state:** returns to IDLE immediately and asynchronously. The in-flight operation is discarded and no `res_vld` pulse is produced.
- **`arg_vld` outside IDLE:** no effect.

## Structure
- Package `square_pkg`:
  - State enum typedef `square_state_t` {IDLE, MUL, ADD, DONE}.
  - Counter width localparam `$clog2(DATA_WIDTH/2)` (minimum 1).
- One sub-module, `reg_rst_n`: a parameterized-width register with asynchronous active-low clear and enable. It is used for `acc`, `mcand`, `mplier`, `rem`, `cnt`, `err`, and the state register.
- Top-level logic is the FSM next-state logic plus the shift-add datapath.

## Test plan
- `root=11, rem=0` -> `res=121`, `res_err=0`, `res_vld` 5 cycles after accept.
- `root=15, rem=30` -> `res=255`, `res_err=0`. `root=0, rem=0` -> `res=0`, `res_err=0`.
- `root=3, rem=7` -> `res=16`, `res_err=1`. Separately, `root=15, rem=31` -> `res=0` (wrap), `res_err=1`.
- Backpressure: `root=7, rem=2`, `res_rdy` low for 10 cycles -> `res=51` held, `res_vld=1` and `arg_rdy=0` throughout. Transfer occurs on the `res_rdy` edge, then `arg_rdy=1`.
- Reset mid-MUL: accept `root=9`, pulse `rst_n` low 2 cycles after accept -> `res_vld` never rises, outputs read 0, `arg_rdy=1`. The next operand `root=5, rem=1` -> `res=26`.
- Streaming: 16 operand pairs with `arg_vld`/`res_rdy` held high -> accepts every 7 cycles, results in order, all matching `r*r+m`.

Source files
------------

// File: rtl/square_pkg.sv
// Shared types and sizing helpers for the root/remainder reconstruction block.
package square_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } square_state_t;

  localparam int unsigned STATE_W = 2;

  // Iteration counter width for a given data width: clog2(width/2), at least 1.
  function automatic int unsigned cnt_width(input int unsigned data_width);
    if ((data_width / 2) <= 2) return 1;
    return $clog2(data_width / 2);
  endfunction

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned CNT_W_DEF      = cnt_width(DATA_WIDTH_DEF);

endpackage

// File: rtl/square_multi_cycle_if.sv
// Operand and result handshake bundle for square_multi_cycle.
// master: producer of operands / consumer of results; slave: the block itself.
interface square_multi_cycle_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  localparam int unsigned HALF  = DATA_WIDTH / 2;
  localparam int unsigned REM_W = HALF + 1;

  logic                  arg_vld;
  logic                  arg_rdy;
  logic [HALF-1:0]       arg_root;
  logic [REM_W-1:0]      arg_rem;
  logic                  res_vld;
  logic                  res_rdy;
  logic [DATA_WIDTH-1:0] res;
  logic                  res_err;

  modport master (
    output arg_vld, arg_root, arg_rem, res_rdy,
    input  arg_rdy, res_vld, res, res_err
  );

  modport slave (
    input  arg_vld, arg_root, arg_rem, res_rdy,
    output arg_rdy, res_vld, res, res_err
  );
endinterface

// File: rtl/reg_rst_n.sv
// Parameterized register with asynchronous active-low clear and load enable.
// Ports: clk, rst_n, en (load), d (next value), q (held value).
module reg_rst_n #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/square_multi_cycle.sv
// Reconstructs r*r + m from a root/remainder pair with a shift-add multiplier.
// Ports: clk, rst_n (async active-low), bus (slave side of square_multi_cycle_if:
// arg_vld/arg_rdy/arg_root/arg_rem in, res_vld/res_rdy/res/res_err out).
module square_multi_cycle
  import square_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  square_multi_cycle_if.slave bus
);

  localparam int unsigned HALF  = DATA_WIDTH / 2;
  localparam int unsigned REM_W = HALF + 1;
  localparam int unsigned CNT_W = cnt_width(DATA_WIDTH);

  square_state_t         state_q, state_d;
  logic [STATE_W-1:0]    state_raw;

  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
  logic [HALF-1:0]       mplier_q, mplier_d;
  logic [REM_W-1:0]      rem_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] res_q, res_d;
  logic                  res_err_q;

  logic                  load_en;
  logic                  mul_en;
  logic                  add_en;

  assign state_q = square_state_t'(state_raw);

  // Next-state and control decode.
  always_comb begin
    state_d = state_q;
    load_en = 1'b0;
    mul_en  = 1'b0;
    add_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.arg_vld) begin
          load_en = 1'b1;
          state_d = MUL;
        end
      end
      MUL: begin
        mul_en = 1'b1;
        if (cnt_q == CNT_W'(HALF - 1)) state_d = ADD;
      end
      ADD: begin
        add_en  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        if (bus.res_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Shift-add datapath; the accept edge seeds the operands.
  always_comb begin
    acc_d    = load_en ? '0 : acc_q + (mplier_q[0] ? mcand_q : '0);
    mcand_d  = load_en ? DATA_WIDTH'(bus.arg_root) : (mcand_q << 1);
    mplier_d = load_en ? bus.arg_root : (mplier_q >> 1);
    cnt_d    = load_en ? '0 : cnt_q + CNT_W'(1);
    // {root,0} is 2r and always fits the remainder width.
    err_d    = bus.arg_rem > {bus.arg_root, 1'b0};
    res_d    = acc_q + DATA_WIDTH'(rem_q);
  end

  reg_rst_n #(.WIDTH(STATE_W)) u_state (
    .clk(clk), .rst_n(rst_n), .en(1'b1), .d(STATE_W'(state_d)), .q(state_raw));

  reg_rst_n #(.WIDTH(DATA_WIDTH)) u_acc (
    .clk(clk), .rst_n(rst_n), .en(load_en | mul_en), .d(acc_d), .q(acc_q));

  reg_rst_n #(.WIDTH(DATA_WIDTH)) u_mcand (
    .clk(clk), .rst_n(rst_n), .en(load_en | mul_en), .d(mcand_d), .q(mcand_q));

  reg_rst_n #(.WIDTH(HALF)) u_mplier (
    .clk(clk), .rst_n(rst_n), .en(load_en | mul_en), .d(mplier_d), .q(mplier_q));

  reg_rst_n #(.WIDTH(CNT_W)) u_cnt (
    .clk(clk), .rst_n(rst_n), .en(load_en | mul_en), .d(cnt_d), .q(cnt_q));

  reg_rst_n #(.WIDTH(REM_W)) u_rem (
    .clk(clk), .rst_n(rst_n), .en(load_en), .d(bus.arg_rem), .q(rem_q));

  reg_rst_n #(.WIDTH(1)) u_err (
    .clk(clk), .rst_n(rst_n), .en(load_en), .d(err_d), .q(err_q));

  // Result registers load in ADD and hold until the next ADD.
  reg_rst_n #(.WIDTH(DATA_WIDTH)) u_res (
    .clk(clk), .rst_n(rst_n), .en(add_en), .d(res_d), .q(res_q));

  reg_rst_n #(.WIDTH(1)) u_res_err (
    .clk(clk), .rst_n(rst_n), .en(add_en), .d(err_q), .q(res_err_q));

  assign bus.arg_rdy = (state_q == IDLE);
  assign bus.res_vld = (state_q == DONE);
  assign bus.res     = res_q;
  assign bus.res_err = res_err_q;

endmodule

// File: tb/tb_square_multi_cycle.sv
module tb_square_multi_cycle;

  localparam int unsigned DW = 8;

  typedef struct {
    int    root;
    int    rem;
    int    exp_res;
    int    exp_err;
    string name;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   cyc;
  logic mon_en;
  int   got_q[$];
  int   exp_q[$];

  square_multi_cycle_if #(.DATA_WIDTH(DW)) bus ();

  square_multi_cycle #(.DATA_WIDTH(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every result presented while res_rdy is high is consumed on the next edge.
  always @(negedge clk)
    if (mon_en && bus.res_vld && bus.res_rdy) got_q.push_back(int'(bus.res));

  function automatic int model_res(input int r, input int m);
    return (r * r + m) % (1 << DW);
  endfunction

  function automatic int model_err(input int r, input int m);
    return (m > 2 * r) ? 1 : 0;
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  // Waits for IDLE, issues one operand pair, returns result and latency.
  task automatic do_op(input int r, input int m, output int got_res,
                       output int got_err, output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.arg_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("arg_rdy_wait", int'(bus.arg_rdy), 1);
    bus.arg_root = 4'(r);
    bus.arg_rem  = 5'(m);
    bus.arg_vld  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.arg_vld  = 1'b0;
    bus.arg_root = 4'($urandom);
    bus.arg_rem  = 5'($urandom);
    n = 0;
    while (!bus.res_vld && n < 50) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    if (!bus.res_vld) check("res_vld_timeout", 0, 1);
    got_res = int'(bus.res);
    got_err = int'(bus.res_err);
    lat     = n;
  endtask

  initial begin
    vec_t vecs[$];
    int   gr, ge, lat, n, bad, acc_cyc, prev_cyc;

    n_checks    = 0;
    n_fail      = 0;
    cyc         = 0;
    mon_en      = 1'b0;
    rst_n       = 1'b0;
    bus.arg_vld  = 1'b0;
    bus.arg_root = '0;
    bus.arg_rem  = '0;
    bus.res_rdy  = 1'b1;

    vecs.push_back('{11, 0, 121, 0, "r11_m0"});
    vecs.push_back('{15, 30, 255, 0, "r15_m30"});
    vecs.push_back('{0, 0, 0, 0, "r0_m0"});
    vecs.push_back('{3, 7, 16, 1, "r3_m7_err"});
    vecs.push_back('{15, 31, 0, 1, "r15_m31_wrap"});
    vecs.push_back('{1, 2, 3, 0, "r1_m2"});
    vecs.push_back('{0, 1, 1, 1, "r0_m1_err"});

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_arg_rdy", int'(bus.arg_rdy), 1);
    check("reset_res_vld", int'(bus.res_vld), 0);
    check("reset_res", int'(bus.res), 0);
    check("reset_res_err", int'(bus.res_err), 0);
    rst_n = 1'b1;

    // Directed table.
    foreach (vecs[i]) begin
      do_op(vecs[i].root, vecs[i].rem, gr, ge, lat);
      check({vecs[i].name, "_res"}, gr, vecs[i].exp_res);
      check({vecs[i].name, "_err"}, ge, vecs[i].exp_err);
      check({vecs[i].name, "_lat"}, lat, 5);
    end

    // Randomized pairs against the arithmetic model, legal and illegal.
    for (int i = 0; i < 24; i++) begin
      int r, m;
      r = int'($urandom_range(0, 15));
      m = int'($urandom_range(0, 31));
      do_op(r, m, gr, ge, lat);
      check("rand_res", gr, model_res(r, m));
      check("rand_err", ge, model_err(r, m));
    end

    // Backpressure: DONE held with stable outputs while res_rdy is low.
    @(negedge clk);
    bus.res_rdy = 1'b0;
    do_op(7, 2, gr, ge, lat);
    check("bp_res", gr, 51);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.res_vld !== 1'b1 || bus.arg_rdy !== 1'b0 || int'(bus.res) != 51 ||
          bus.res_err !== 1'b0) bad++;
    end
    check("bp_hold_bad_cycles", bad, 0);
    bus.res_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_after_arg_rdy", int'(bus.arg_rdy), 1);
    check("bp_after_res_vld", int'(bus.res_vld), 0);
    check("bp_after_res_kept", int'(bus.res), 51);

    // Reset mid-MUL discards the operation.
    bus.arg_root = 4'd9;
    bus.arg_rem  = 5'd3;
    bus.arg_vld  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.arg_vld = 1'b0;
    check("rst_mid_in_flight", int'(bus.arg_rdy), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_arg_rdy", int'(bus.arg_rdy), 1);
    check("rst_mid_res_vld", int'(bus.res_vld), 0);
    check("rst_mid_res", int'(bus.res), 0);
    check("rst_mid_res_err", int'(bus.res_err), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.res_vld !== 1'b0 || bus.arg_rdy !== 1'b1) bad++;
    end
    check("rst_mid_no_result", bad, 0);
    do_op(5, 1, gr, ge, lat);
    check("post_rst_res", gr, 26);
    check("post_rst_err", ge, 0);
    check("post_rst_lat", lat, 5);

    // Streaming with arg_vld and res_rdy held high.
    @(negedge clk);
    while (!bus.arg_rdy) @(negedge clk);
    got_q.delete();
    exp_q.delete();
    mon_en   = 1'b1;
    prev_cyc = -1;
    bad      = 0;
    bus.arg_vld = 1'b1;
    for (int i = 0; i < 16; i++) begin
      int r, m;
      r = int'($urandom_range(0, 15));
      m = int'($urandom_range(0, 2 * r));
      bus.arg_root = 4'(r);
      bus.arg_rem  = 5'(m);
      exp_q.push_back(model_res(r, m));
      n = 0;
      while (!bus.arg_rdy && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (!bus.arg_rdy) check("stream_accept_timeout", 0, 1);
      @(posedge clk);
      @(negedge clk);
      acc_cyc = cyc;
      if (prev_cyc >= 0 && acc_cyc - prev_cyc != 7) bad++;
      prev_cyc = acc_cyc;
    end
    bus.arg_vld = 1'b0;
    n = 0;
    while (got_q.size() < 16 && n < 40) begin
      @(negedge clk);
      n++;
    end
    mon_en = 1'b0;
    check("stream_spacing_bad", bad, 0);
    check("stream_count", got_q.size(), 16);
    bad = 0;
    for (int i = 0; i < 16; i++)
      if (i >= got_q.size() || got_q[i] != exp_q[i]) bad++;
    check("stream_values_bad", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
